ro_puf_ctrl: RTL
================

# ro_puf_ctrl

Measurement controller for the ring-oscillator PUF. It takes a 10-bit challenge and drives the select inputs of two 32:1 ring-oscillator multiplexers (A and B) and the shared ring enable. After a settle period, it counts rising edges on both multiplexer outputs over a fixed window of clocks. It then compares the two counts and reports one response bit, plus the raw counts, to the host logic.

## Interface
Parameters:
- WINDOW, 1024: length of the counting window, in clk cycles. Must be ≥ 1.
- SETTLE, 8: clk cycles between ring enable/select change and the start of counting. Must be ≥ 3.
- CNT_W, 16: width of each edge counter. Counters saturate.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request. Sampled only in IDLE.
- challenge  in  10  [4:0] selects oscillator A, [9:5] selects oscillator B.
- ro_a  in  1  output of mux A. Asynchronous to clk.
- ro_b  in  1  output of mux B. Asynchronous to clk.
- sel_a  out  5  select for mux A.
- sel_b  out  5  select for mux B.
- ro_en  out  1  ring oscillator enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- response  out  1  1 if cnt_a > cnt_b, else 0.
- tie  out  1  cnt_a == cnt_b.
- err  out  1  challenge was rejected because sel_a == sel_b.
- cnt_a  out  CNT_W  final edge count for oscillator A.
- cnt_b  out  CNT_W  final edge count for oscillator B.

## Operation
- ro_a and ro_b each pass through a 2-flop synchronizer, followed by a registered rising-edge detector. The synchronizers run continuously.
- The FSM has states IDLE, SETTLE, COUNT, CMP.
- IDLE
  - start=1 and challenge[4:0] ≠ challenge[9:5]:
    - latch sel_a and sel_b from the challenge;
    - set ro_en=1;
    - clear both counters and the timer;
    - clear err;
    - go to SETTLE.
  - start=1 and the two halves are equal:
    - latch the selects;
    - set err=1, response=0, tie=0, cnt_a=cnt_b=0;
    - pulse done next cycle;
    - stay in IDLE. ro_en never asserts.
- SETTLE
  - Runs for SETTLE cycles. Detected edges are ignored, which flushes stale synchronizer state.
  - Then go to COUNT.
- COUNT
  - Runs for WINDOW cycles.
  - Each cycle, a detected edge on A or B increments its counter. Both may increment in the same cycle.
  - A counter at 2^CNT_W−1 holds its value (saturates).
  - Then go to CMP.
- CMP (one cycle)
  - Register response = (cnt_a > cnt_b) and tie = (cnt_a == cnt_b), using unsigned compare.
  - Drop ro_en to 0.
  - Pulse done.
  - Return to IDLE.
- cnt_a, cnt_b, response, tie and err hold their values until the next accepted start. sel_a and sel_b hold until the next start.
- start while busy is ignored. No queuing.
- Reset at any point, including mid-COUNT, aborts the measurement with no done pulse.
  - All outputs return to 0; state returns to IDLE.
  - This is the reset value of every output: sel_a=sel_b=0, ro_en=0, busy=0, done=0, response=0, tie=0, err=0, cnt_a=cnt_b=0.

## Timing
- start is sampled at edge T.
  - sel_a, sel_b, ro_en and busy are valid from cycle T+1.
  - SETTLE occupies cycles T+1 … T+SETTLE.
  - COUNT occupies cycles T+SETTLE+1 … T+SETTLE+WINDOW.
  - CMP, with done=1 and results valid, is cycle T+SETTLE+WINDOW+1.
  - busy falls in the same cycle that done rises. ro_en is 0 from T+SETTLE+WINDOW+2.
- The next start is accepted at the earliest in the cycle after done.
- Rejected challenge: done=1 and err=1 in cycle T+1. busy stays 0.
- Maximum countable oscillator frequency is clk/2 after synchronization. Faster inputs alias, which is accepted behaviour.
- Edge-detect pipeline latency is 3 cycles. Counts are exact only to ±1 relative to the ideal window.

## Test plan
- Reset: hold rst for 2 cycles with random inputs → every output is 0, busy=0; start asserted during rst is ignored.
- ro_a toggles every 2 clk (period 4), ro_b every 4 clk (period 8); WINDOW=64, SETTLE=8; challenge={5'd17,5'd3} → sel_a=3, sel_b=17; done exactly 73 cycles after start; cnt_a=16±1, cnt_b=8±1; response=1, tie=0, err=0.
- Same stimulus with the ro_a and ro_b waveforms swapped → response=0, tie=0; counts swapped.
- ro_a and ro_b driven by the identical waveform (period 8) → cnt_a==cnt_b==8, tie=1, response=0.
- challenge={5'd9,5'd9} → done and err in cycle T+1; ro_en and busy never assert; cnt_a=cnt_b=0.
- CNT_W=4, WINDOW=64, ro_a period 4 → cnt_a saturates at 15. In a second run:
  - start pulsed mid-COUNT is ignored;
  - rst asserted mid-COUNT gives no done pulse, and all outputs are 0 the next cycle;
  - a fresh start after reset completes normally.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF measurement controller: selects two rings, lets them settle,
// counts synchronized rising edges over a fixed window and reports which ring is faster.
module ro_puf_ctrl #(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       challenge,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [4:0]       sel_a,
    output logic [4:0]       sel_b,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    WINDOW_LAST = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_CMP    = 2'd3
    } state_t;

    state_t           state_r;
    logic [TW-1:0]    timer_r;
    logic [1:0]       sync_a_r;
    logic [1:0]       sync_b_r;
    logic             prev_a_r;
    logic             prev_b_r;
    logic             rise_a_r;
    logic             rise_b_r;
    logic [CNT_W-1:0] cnt_a_nxt_s;
    logic [CNT_W-1:0] cnt_b_nxt_s;

    // Free-running 2-flop synchronizers followed by registered rising-edge detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= 2'b00;
            sync_b_r <= 2'b00;
            prev_a_r <= 1'b0;
            prev_b_r <= 1'b0;
            rise_a_r <= 1'b0;
            rise_b_r <= 1'b0;
        end else begin
            sync_a_r <= {sync_a_r[0], ro_a};
            sync_b_r <= {sync_b_r[0], ro_b};
            prev_a_r <= sync_a_r[1];
            prev_b_r <= sync_b_r[1];
            rise_a_r <= sync_a_r[1] & ~prev_a_r;
            rise_b_r <= sync_b_r[1] & ~prev_b_r;
        end
    end

    // Saturating next-count values; the final COUNT cycle compares these directly.
    always_comb begin
        cnt_a_nxt_s = cnt_a;
        cnt_b_nxt_s = cnt_b;
        if (rise_a_r && (cnt_a != CNT_MAX)) begin
            cnt_a_nxt_s = cnt_a + CNT_W'(1);
        end else begin
            cnt_a_nxt_s = cnt_a;
        end
        if (rise_b_r && (cnt_b != CNT_MAX)) begin
            cnt_b_nxt_s = cnt_b + CNT_W'(1);
        end else begin
            cnt_b_nxt_s = cnt_b;
        end
    end

    // Measurement sequencer with all host-visible outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            timer_r  <= '0;
            sel_a    <= 5'd0;
            sel_b    <= 5'd0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b0;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        sel_a    <= challenge[4:0];
                        sel_b    <= challenge[9:5];
                        cnt_a    <= '0;
                        cnt_b    <= '0;
                        response <= 1'b0;
                        tie      <= 1'b0;
                        timer_r  <= '0;
                        if (challenge[4:0] != challenge[9:5]) begin
                            ro_en   <= 1'b1;
                            busy    <= 1'b1;
                            err     <= 1'b0;
                            state_r <= S_SETTLE;
                        end else begin
                            // Identical rings would always tie; reject without enabling them.
                            err  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        timer_r <= '0;
                        state_r <= S_COUNT;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_COUNT: begin
                    cnt_a <= cnt_a_nxt_s;
                    cnt_b <= cnt_b_nxt_s;
                    if (timer_r == WINDOW_LAST) begin
                        response <= (cnt_a_nxt_s > cnt_b_nxt_s);
                        tie      <= (cnt_a_nxt_s == cnt_b_nxt_s);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        timer_r  <= '0;
                        state_r  <= S_CMP;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_CMP: begin
                    ro_en   <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
